mem_io_ctrl: RTL and testbench
==============================

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 10: RAM word-address width (4 KiB data RAM).
REQ-002 SHALL have parameter KFIFO_DEPTH, default 8: keyboard FIFO depth; the design SHALL support only 8.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req  input  1  CPU data-access request; held until cpu_ready.
REQ-006 SHALL have port cpu_wren  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cpu_addr  input  32  byte address.
REQ-008 SHALL have port cpu_wdata  input  32  store data.
REQ-009 SHALL have port cpu_rdata  output  32  load data, valid while cpu_ready=1.
REQ-010 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ram_addr  output  RAM_AW  RAM word address.
REQ-012 SHALL have port ram_wdata  output  32  RAM write data.
REQ-013 SHALL have port ram_we  output  1  RAM write enable.
REQ-014 SHALL have port ram_rdata  input  32  RAM read data, one-cycle latency after address.
REQ-015 SHALL have port kbd_valid  input  1  scan-code strobe, one per cycle max.
REQ-016 SHALL have port kbd_data  input  8  scan code.
REQ-017 SHALL have port led  output  32  LED register.

Function
REQ-018 Address map (cpu_addr[1:0] ignored): 0x0000_0000-0x0000_0FFF RAM (ram_addr=addr[11:2]); 0x1000 KBD_STATUS (RO); 0x1004 KBD_DATA (RO, pop); 0x1008 LED (R/W); all others read 0, writes ignored, still complete.
REQ-019 FSM states IDLE, ACCESS, WAIT, DONE; IDLE with cpu_req=1 -> ACCESS, latching addr/wdata/wren; cpu_req ignored outside IDLE.
REQ-020 ACCESS -> WAIT for RAM reads; ACCESS -> DONE for all other accesses; WAIT -> DONE capturing ram_rdata; DONE -> IDLE unconditionally.
REQ-021 Latency from accepting edge: cpu_ready high in cycle 2 for writes and I/O reads, cycle 3 for RAM reads; cpu_ready high exactly one cycle (DONE), cpu_rdata held until the next completion.
REQ-022 ram_we SHALL be 1 only during ACCESS of a RAM write; ram_addr/ram_wdata driven from latched request in ACCESS and held otherwise.
REQ-023 LED write updates led at the ACCESS->DONE edge; LED read returns led.
REQ-024 KBD_STATUS read = {26'b0, overflow, count[3:0], nonempty}; count range 0-8.
REQ-025 kbd_valid pushes kbd_data when count<8; when full and no same-cycle pop, the code is dropped and overflow set (sticky).
REQ-026 Reading KBD_STATUS clears overflow at the ACCESS->DONE edge; a same-edge new overflow SHALL win (overflow stays 1).
REQ-027 KBD_DATA read returns {24'b0, head} and pops at the ACCESS->DONE edge; when empty returns 0, no pop, count unchanged.
REQ-028 Simultaneous push and pop: both occur, count unchanged, no overflow even when full; push into empty FIFO during an empty-pop returns 0 and count becomes 1.
REQ-029 FIFO pointers are 3-bit, wrap 7->0; order strictly first-in first-out.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, cpu_ready 0, cpu_rdata 0, ram_we 0, ram_addr 0, ram_wdata 0, led 0, FIFO empty, pointers 0, overflow 0.
REQ-031 Reset asserted mid-transaction abandons it: no completion pulse, no pop, no LED update after reset releases.

Verification
REQ-032 SW 0x0000_0010 data 0xDEADBEEF -> ram_we=1 one cycle with ram_addr=4, ram_wdata=0xDEADBEEF; cpu_ready in cycle 2; then LW same addr -> cpu_rdata=0xDEADBEEF, cpu_ready in cycle 3.
REQ-033 Push 0x1C,0x32,0x21, read KBD_STATUS -> 0x0000_0007; read KBD_DATA three times -> 0x1C,0x32,0x21; fourth read -> 0, status 0.
REQ-034 Push 9 codes 0x01-0x09 -> status 0x0000_0031; read status again -> 0x0000_0011; drain returns 0x01-0x08.
REQ-035 FIFO full, KBD_DATA pop coinciding with kbd_valid 0x55 -> count stays 8, overflow 0, 0x55 read last.
REQ-036 Write LED 0x0000_00A5 then read 0x1008 -> 0xA5; read 0x2000 -> 0; rst=0 during a RAM read's WAIT -> no cpu_ready, led=0.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: memory/IO controller between a CPU data port, a word-wide data RAM,
// a keyboard scan-code FIFO and an LED register.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   cpu_req    - CPU access request, held until cpu_ready
//   cpu_wren   - 1 = write, 0 = read
//   cpu_addr   - byte address (bits [1:0] ignored)
//   cpu_wdata  - store data
//   cpu_rdata  - load data, held until the next completion
//   cpu_ready  - one-cycle completion pulse
//   ram_addr   - RAM word address
//   ram_wdata  - RAM write data
//   ram_we     - RAM write enable
//   ram_rdata  - RAM read data, one cycle after ram_addr
//   kbd_valid  - scan-code strobe
//   kbd_data   - scan code
//   led        - LED register
//
// Address map: 0x0000-0x0FFF RAM, 0x1000 KBD_STATUS, 0x1004 KBD_DATA (pop),
// 0x1008 LED; every other address reads 0 and ignores writes.
module mem_io_ctrl #(
  parameter int RAM_AW      = 10,
  parameter int KFIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic [31:0]       led
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} StateT;

  StateT             r_state;
  StateT             w_nextState;
  logic [31:2]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_wren;
  logic [RAM_AW-1:0] r_ramAddr;
  logic [31:0]       r_ramWdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_led;
  logic [7:0]        r_fifo [KFIFO_DEPTH];
  logic [2:0]        r_wrPtr;
  logic [2:0]        r_rdPtr;
  logic [3:0]        r_count;
  logic              r_overflow;

  logic        w_isRam;
  logic        w_isStatus;
  logic        w_isData;
  logic        w_isLed;
  logic        w_accept;
  logic        w_accRead;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovfSet;
  logic        w_ovfClr;
  logic [31:0] w_ioRdata;
  logic        w_unusedAddrBits;

  // Byte-lane bits carry no meaning for word accesses.
  assign w_unusedAddrBits = ^cpu_addr[1:0];

  // Decode is done on the latched address so it is stable for the whole access.
  assign w_isRam    = (r_addr[31:12] == 20'h0);
  assign w_isStatus = (r_addr == 30'h400);
  assign w_isData   = (r_addr == 30'h401);
  assign w_isLed    = (r_addr == 30'h402);

  assign w_accept  = (r_state == IDLE) && cpu_req;
  assign w_accRead = (r_state == ACCESS) && !r_wren;
  assign w_full    = (r_count == 4'(KFIFO_DEPTH));

  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted (and does not overflow) when it coincides with a pop.
  assign w_pop    = w_accRead && w_isData && (r_count != 4'd0);
  assign w_push   = kbd_valid && (!w_full || w_pop);
  assign w_ovfSet = kbd_valid && w_full && !w_pop;
  assign w_ovfClr = w_accRead && w_isStatus;

  assign cpu_ready = (r_state == DONE);
  assign cpu_rdata = r_rdata;
  assign ram_we    = (r_state == ACCESS) && r_wren && w_isRam;
  assign ram_addr  = r_ramAddr;
  assign ram_wdata = r_ramWdata;
  assign led       = r_led;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_nextState = ACCESS;
      ACCESS:  w_nextState = (w_isRam && !r_wren) ? WAIT : DONE;
      WAIT:    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Read value for the I/O window; unmapped addresses fall through to 0.
  always_comb begin
    w_ioRdata = 32'h0;
    if (w_isStatus)
      w_ioRdata = {26'h0, r_overflow, r_count, (r_count != 4'd0)};
    else if (w_isData && (r_count != 4'd0))
      w_ioRdata = {24'h0, r_fifo[r_rdPtr]};
    else if (w_isLed)
      w_ioRdata = r_led;
  end

  // The RAM-side address/data only change when a RAM request is accepted,
  // so they stay put during I/O traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wren     <= 1'b0;
      r_ramAddr  <= '0;
      r_ramWdata <= '0;
    end else if (w_accept) begin
      r_addr  <= cpu_addr[31:2];
      r_wdata <= cpu_wdata;
      r_wren  <= cpu_wren;
      if (cpu_addr[31:12] == 20'h0) begin
        r_ramAddr  <= cpu_addr[RAM_AW+1:2];
        r_ramWdata <= cpu_wdata;
      end
    end
  end

  // Load data is captured once per read and held until the next read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_led   <= '0;
    end else begin
      if (w_accRead && !w_isRam)
        r_rdata <= w_ioRdata;
      else if (r_state == WAIT)
        r_rdata <= ram_rdata;
      if ((r_state == ACCESS) && r_wren && w_isLed)
        r_led <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wrPtr] <= kbd_data;
  end

  // Overflow is sticky; a new overflow on the clearing edge takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= 3'd0;
      r_rdPtr    <= 3'd0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 3'd1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 3'd1;
      if (w_push && !w_pop)      r_count <= r_count + 4'd1;
      else if (w_pop && !w_push) r_count <= r_count - 4'd1;
      if (w_ovfSet)      r_overflow <= 1'b1;
      else if (w_ovfClr) r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: directed plus randomized bench for mem_io_ctrl. A behavioural
// model (word array, scan-code queue, overflow flag, LED value) predicts every
// read value, completion latency and RAM write strobe.
module tb_mem_io_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic [31:0] led;

  int total = 0;
  int bad   = 0;

  logic [31:0] ramMem [1024];
  logic [31:0] refMem [1024];
  logic [7:0]  refQ [$];
  logic        refOvf;
  logic [31:0] refLed;

  mem_io_ctrl #(.RAM_AW(10), .KFIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_wren  (cpu_wren),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .led       (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] statusWord();
    return {26'h0, refOvf, 4'(refQ.size()), (refQ.size() != 0)};
  endfunction

  function automatic void modelPush(input logic [7:0] c);
    if (refQ.size() < 8) refQ.push_back(c);
    else refOvf = 1'b1;
  endfunction

  task automatic pushKey(input logic [7:0] c);
    @(negedge clk);
    kbd_valid = 1'b1;
    kbd_data  = c;
    @(negedge clk);
    kbd_valid = 1'b0;
    modelPush(c);
  endtask

  // One CPU transaction; cycle 1 is the cycle right after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic doPush, input logic [7:0] code,
                               output logic [31:0] rd, output int lat, output int weCnt,
                               output logic [31:0] weAddr, output logic [31:0] weData);
    rd = 32'h0; lat = 0; weCnt = 0; weAddr = 32'h0; weData = 32'h0;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_wren  = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(posedge clk); #1;
    if (doPush) begin
      kbd_valid = 1'b1;
      kbd_data  = code;
    end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      if (cyc == 2) kbd_valid = 1'b0;
      if (ram_we === 1'b1) begin
        weCnt++;
        weAddr = {22'h0, ram_addr};
        weData = ram_wdata;
      end
      if (cpu_ready === 1'b1) begin
        lat = cyc;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req   = 1'b0;
    kbd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic runAndCheck(input string tag, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic doPush, input logic [7:0] code,
                             output logic [31:0] rd);
    logic [31:0] expRd, wordA, weAddr, weData;
    logic        isRam;
    int          expLat, lat, weCnt;
    wordA  = {a[31:2], 2'b00};
    isRam  = (a < 32'h1000);
    expRd  = 32'h0;
    expLat = 2;
    if (isRam && !wr) begin
      expRd  = refMem[a[11:2]];
      expLat = 3;
    end else if (!wr && wordA == 32'h1000) expRd = statusWord();
    else if (!wr && wordA == 32'h1004) expRd = (refQ.size() > 0) ? {24'h0, refQ[0]} : 32'h0;
    else if (!wr && wordA == 32'h1008) expRd = refLed;

    applyStimulus(wr, a, wd, doPush, code, rd, lat, weCnt, weAddr, weData);

    if (isRam && wr) refMem[a[11:2]] = wd;
    if (wr && wordA == 32'h1008) refLed = wd;
    if (!wr && wordA == 32'h1000) refOvf = 1'b0;
    if (!wr && wordA == 32'h1004 && refQ.size() > 0) void'(refQ.pop_front());
    if (doPush) modelPush(code);

    checkOutput({tag, "_lat"}, lat, expLat);
    if (!wr) begin
      checkOutput({tag, "_rdata"}, rd, expRd);
      checkOutput({tag, "_hold"}, cpu_rdata, expRd);
    end
    checkOutput({tag, "_rdyLow"}, {31'h0, cpu_ready}, 32'h0);
    checkOutput({tag, "_weCnt"}, weCnt, (isRam && wr) ? 1 : 0);
    if (isRam && wr) begin
      checkOutput({tag, "_weAddr"}, weAddr, {22'h0, a[11:2]});
      checkOutput({tag, "_weData"}, weData, wd);
    end
    checkOutput({tag, "_led"}, led, refLed);
  endtask

  initial begin
    logic [31:0] rd;
    logic        sawReady;
    int          op;
    logic [31:0] a;

    for (int i = 0; i < 1024; i++) begin
      ramMem[i] = 32'h0;
      refMem[i] = 32'h0;
    end
    refOvf    = 1'b0;
    refLed    = 32'h0;
    cpu_req   = 1'b0;
    cpu_wren  = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    kbd_valid = 1'b0;
    kbd_data  = 8'h0;

    // Reset state
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_ready", {31'h0, cpu_ready}, 32'h0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_we", {31'h0, ram_we}, 32'h0);
    checkOutput("rst_raddr", {22'h0, ram_addr}, 32'h0);
    checkOutput("rst_rwdata", ram_wdata, 32'h0);
    checkOutput("rst_led", led, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // RAM store then load
    runAndCheck("sw", 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 8'h0, rd);
    runAndCheck("lw", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("lw_const", rd, 32'hDEADBEEF);

    // Three scan codes in order, then empty
    pushKey(8'h1C); pushKey(8'h32); pushKey(8'h21);
    runAndCheck("st3", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("st3_const", rd, 32'h7);
    runAndCheck("kd1", 1'b0, 32'h1004, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("kd1_const", rd, 32'h1C);
    runAndCheck("kd2", 1'b0, 32'h1004, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("kd2_const", rd, 32'h32);
    runAndCheck("kd3", 1'b0, 32'h1004, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("kd3_const", rd, 32'h21);
    runAndCheck("kd4", 1'b0, 32'h1004, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("kd4_const", rd, 32'h0);
    runAndCheck("st0", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("st0_const", rd, 32'h0);

    // Overflow: nine pushes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) pushKey(8'(i));
    runAndCheck("stOvf", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("stOvf_const", rd, 32'h31);
    runAndCheck("stClr", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("stClr_const", rd, 32'h11);
    for (int i = 1; i <= 8; i++) begin
      runAndCheck("drain", 1'b0, 32'h1004, 32'h0, 1'b0, 8'h0, rd);
      checkOutput("drain_const", rd, 32'(i));
    end

    // Full FIFO: pop and push on the same edge
    for (int i = 0; i < 8; i++) pushKey(8'hA0 + 8'(i));
    runAndCheck("popPush", 1'b0, 32'h1004, 32'h0, 1'b1, 8'h55, rd);
    checkOutput("popPush_const", rd, 32'hA0);
    runAndCheck("stFull", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("stFull_const", rd, 32'h11);
    for (int i = 0; i < 8; i++) runAndCheck("drain2", 1'b0, 32'h1004, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("last55", rd, 32'h55);

    // Empty pop coinciding with a push
    runAndCheck("emptyPush", 1'b0, 32'h1004, 32'h0, 1'b1, 8'h77, rd);
    checkOutput("emptyPush_const", rd, 32'h0);
    runAndCheck("stOne", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("stOne_const", rd, 32'h3);

    // LED and unmapped space
    runAndCheck("ledW", 1'b1, 32'h1008, 32'h0000_00A5, 1'b0, 8'h0, rd);
    runAndCheck("ledR", 1'b0, 32'h1008, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("ledR_const", rd, 32'hA5);
    runAndCheck("unmapR", 1'b0, 32'h2000, 32'h0, 1'b0, 8'h0, rd);
    runAndCheck("unmapW", 1'b1, 32'h2000, 32'h1234_5678, 1'b0, 8'h0, rd);
    runAndCheck("roW", 1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b0, 8'h0, rd);

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 6);
      a  = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      case (op)
        0: runAndCheck("rndSw", 1'b1, a, $urandom, 1'b0, 8'h0, rd);
        1: runAndCheck("rndLw", 1'b0, a, 32'h0, 1'($urandom_range(0, 1)), 8'($urandom), rd);
        2: repeat ($urandom_range(1, 4)) pushKey(8'($urandom));
        3: runAndCheck("rndKd", 1'b0, 32'h1004, 32'h0, 1'($urandom_range(0, 1)), 8'($urandom), rd);
        4: runAndCheck("rndSt", 1'b0, 32'h1000, 32'h0, 1'($urandom_range(0, 1)), 8'($urandom), rd);
        5: runAndCheck("rndLed", 1'($urandom_range(0, 1)), 32'h1008, $urandom, 1'b0, 8'h0, rd);
        default: runAndCheck("rndUnm", 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 1) != 0) ? 32'h100C : 32'hFFFF_FFF0,
                             $urandom, 1'b0, 8'h0, rd);
      endcase
    end

    // Reset during the wait cycle of a RAM read
    runAndCheck("preLed", 1'b1, 32'h1008, 32'h0000_00C3, 1'b0, 8'h0, rd);
    pushKey(8'h11);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_wren = 1'b0;
    cpu_addr = 32'h0000_0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst     = 1'b0;
    cpu_req = 1'b0;
    #1;
    checkOutput("midRst_ready", {31'h0, cpu_ready}, 32'h0);
    checkOutput("midRst_rdata", cpu_rdata, 32'h0);
    checkOutput("midRst_we", {31'h0, ram_we}, 32'h0);
    checkOutput("midRst_raddr", {22'h0, ram_addr}, 32'h0);
    checkOutput("midRst_led", led, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    sawReady = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (cpu_ready === 1'b1) sawReady = 1'b1;
    end
    checkOutput("midRst_noReady", {31'h0, sawReady}, 32'h0);
    checkOutput("midRst_ledAfter", led, 32'h0);
    refLed = 32'h0;
    refOvf = 1'b0;
    refQ.delete();
    runAndCheck("postRstSt", 1'b0, 32'h1000, 32'h0, 1'b0, 8'h0, rd);
    checkOutput("postRstSt_const", rd, 32'h0);

    $display("[TB] comparisons complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
